// File: rtl/fb_write_arbiter.sv
// Round-robin write arbiter between the clear and line engines into a single-entry framebuffer write stage.
// Optional build macro FB_ARB_CLIP_EN: drop off-screen pixels and count them on drop_count.

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

package fb_write_arbiter_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } Point2D;
endpackage

module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_valid,
  input  Point2D             clr_point,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_ready,
  input  logic               ln_valid,
  input  Point2D             ln_point,
  input  logic [COLOR_W-1:0] ln_color,
  output logic               ln_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               idle
`ifdef FB_ARB_CLIP_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                last_ln_q, last_ln_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOR_W-1:0]  data_q, data_d;

  logic                grantable;
  logic                grant_clr, grant_ln, grant;
  logic                load;
  Point2D              sel_pt;
  logic [COLOR_W-1:0]  sel_color;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W-1:0]   x_ext, y_ext;

  // Slot can take a pixel if empty, or if the current one drains this cycle.
  always_comb begin
    grantable = !rst && ((state_q == S_EMPTY) || mem_ack);
    grant_clr = grantable && clr_valid && (!ln_valid || last_ln_q);
    grant_ln  = grantable && ln_valid && (!clr_valid || !last_ln_q);
    grant     = grant_clr || grant_ln;
    sel_pt    = grant_ln ? ln_point : clr_point;
    sel_color = grant_ln ? ln_color : clr_color;
    x_ext     = ADDR_W'($unsigned(sel_pt.x));
    y_ext     = ADDR_W'($unsigned(sel_pt.y));
    sel_addr  = ADDR_W'(y_ext * ADDR_W'(`WIDTH)) + x_ext;
  end

`ifdef FB_ARB_CLIP_EN
  logic        on_screen;
  logic [15:0] drop_q, drop_d;

  always_comb begin
    on_screen = (int'(sel_pt.x) >= 0) && (int'(sel_pt.x) < `WIDTH) &&
                (int'(sel_pt.y) >= 0) && (int'(sel_pt.y) < `HEIGHT);
    load      = grant && on_screen;
    drop_d    = drop_q;
    if (grant && !on_screen && (drop_q != '1))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign load = grant;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_ln_d = last_ln_q;
    if (grant) last_ln_d = grant_ln;
    if (load) begin
      addr_d = sel_addr;
      data_d = sel_color;
    end
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (mem_ack) state_d = load ? S_FULL : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Pointer resets to "line granted last" so clear wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      last_ln_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_ln_q <= last_ln_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign clr_ready = grant_clr;
  assign ln_ready  = grant_ln;
  assign mem_we    = (state_q == S_FULL);
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign idle      = (state_q == S_EMPTY) && !clr_valid && !ln_valid;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized bench for fb_write_arbiter against a transaction-level model, plus directed literal checks.
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif

module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int CW = 8;
  localparam int AW = 19;
  localparam int W  = `WIDTH;
  localparam int H  = `HEIGHT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_valid = 1'b0, ln_valid = 1'b0;
  Point2D        clr_point = '0, ln_point = '0;
  logic [CW-1:0] clr_color = '0, ln_color = '0;
  logic          clr_ready, ln_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic          mem_ack = 1'b1;
  logic          idle;
`ifdef FB_ARB_CLIP_EN
  logic [15:0]   drop_count;
`endif

  fb_write_arbiter #(.COLOR_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .clr_valid(clr_valid), .clr_point(clr_point), .clr_color(clr_color), .clr_ready(clr_ready),
    .ln_valid(ln_valid), .ln_point(ln_point), .ln_color(ln_color), .ln_ready(ln_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .idle(idle)
`ifdef FB_ARB_CLIP_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit acc_clr = 0, acc_ln = 0;

  // Model: the single write slot and who was served most recently.
  bit  m_full = 0;
  int  m_addr = 0, m_data = 0;
  bit  m_last_ln = 1;
  int  m_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit on_screen(input Point2D p);
`ifdef FB_ARB_CLIP_EN
    return int'(p.x) >= 0 && int'(p.x) < W && int'(p.y) >= 0 && int'(p.y) < H;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int addr_of(input Point2D p);
    longint a;
    a = longint'(int'(p.y)) * W + longint'(int'(p.x));
    return int'(a & ((64'd1 << AW) - 1));
  endfunction

  always @(negedge clk) begin
    bit e_gc, e_gl, can;
    Point2D p;
    can  = !rst && (!m_full || mem_ack);
    e_gc = 0; e_gl = 0;
    if (can) begin
      if (clr_valid && ln_valid) begin
        e_gc = m_last_ln;
        e_gl = !m_last_ln;
      end else begin
        e_gc = clr_valid;
        e_gl = ln_valid;
      end
    end
    if (chk_en) begin
      chk("clr_ready", clr_ready, e_gc);
      chk("ln_ready", ln_ready, e_gl);
      chk("mem_we", mem_we, m_full);
      chk("idle", idle, !m_full && !clr_valid && !ln_valid);
      if (m_full) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
`ifdef FB_ARB_CLIP_EN
      chk("drop_count", drop_count, m_drop);
`endif
    end
    acc_clr = clr_valid && clr_ready;
    acc_ln  = ln_valid && ln_ready;
    if (rst) begin
      m_full = 0; m_addr = 0; m_data = 0; m_last_ln = 1; m_drop = 0;
    end else begin
      if (m_full && mem_ack) m_full = 0;
      if (e_gc || e_gl) begin
        m_last_ln = e_gl;
        p = e_gl ? ln_point : clr_point;
        if (on_screen(p)) begin
          m_full = 1;
          m_addr = addr_of(p);
          m_data = int'(e_gl ? ln_color : clr_color);
        end else if (m_drop < 16'hFFFF) begin
          m_drop++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk); #1;
  endtask

  function automatic Point2D mkpt(input int x, input int y);
    Point2D p;
    p.x = 16'(x);
    p.y = 16'(y);
    return p;
  endfunction

  function automatic Point2D rand_pt();
    int x, y;
    x = int'($urandom_range(0, W - 1));
    y = int'($urandom_range(0, H - 1));
`ifdef FB_ARB_CLIP_EN
    case ($urandom_range(0, 11))
      0: x = -1 - int'($urandom_range(0, 20));
      1: x = W + int'($urandom_range(0, 20));
      2: y = -1 - int'($urandom_range(0, 20));
      3: y = H + int'($urandom_range(0, 20));
      default: ;
    endcase
`endif
    return mkpt(x, y);
  endfunction

  task automatic do_reset();
    rst = 1; clr_valid = 0; ln_valid = 0; mem_ack = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    neg();
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset idle", idle, 1);

    // Clear-only stream with mem_ack tied high.
    for (int i = 0; i < 3; i++) begin
      tick();
      clr_valid = 1; clr_point = mkpt(i, 0); clr_color = 8'(i + 1);
      neg();
      chk("stream clr_ready", clr_ready, 1);
      if (i > 0) chk("stream mem_addr", mem_addr, i - 1);
    end
    tick(); clr_valid = 0;
    neg();
    chk("stream last addr", mem_addr, 2);
    chk("stream last we", mem_we, 1);
    tick(); neg();
    chk("stream drained", mem_we, 0);

    // Contention from reset alternates starting with clear.
    do_reset();
    clr_valid = 1; ln_valid = 1;
    clr_point = mkpt(1, 1); ln_point = mkpt(2, 2);
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("rr clr", clr_ready, (i % 2) == 0);
      chk("rr ln", ln_ready, (i % 2) == 1);
      tick();
    end
    clr_valid = 0; ln_valid = 0;

    // Single pixel stalled by mem_ack for 4 cycles.
    do_reset();
    mem_ack = 0;
    clr_valid = 1; clr_point = mkpt(5, 2); clr_color = 8'hA5;
    neg();
    chk("stall accept", clr_ready, 1);
    tick();
    clr_valid = 0; ln_valid = 1; ln_point = mkpt(7, 7); ln_color = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("stall we", mem_we, 1);
      chk("stall addr", mem_addr, 2 * W + 5);
      chk("stall data", mem_wdata, 8'hA5);
      chk("stall ln_ready", ln_ready, 0);
      tick();
    end
    mem_ack = 1;
    neg();
    chk("ack we", mem_we, 1);
    chk("ack ln_ready", ln_ready, 1);
    tick(); ln_valid = 0;
    neg();
    chk("b2b addr", mem_addr, 7 * W + 7);
    chk("b2b data", mem_wdata, 8'h3C);
    tick();

`ifdef FB_ARB_CLIP_EN
    do_reset();
    ln_valid = 1; ln_point = mkpt(-1, 0);
    neg(); chk("clip accept 1", ln_ready, 1);
    tick(); ln_point = mkpt(W, 3);
    neg(); chk("clip accept 2", ln_ready, 1); chk("clip we", mem_we, 0);
    tick(); ln_valid = 0;
    neg(); chk("clip we2", mem_we, 0); chk("clip drops", drop_count, 2);
    tick();
`endif

    // Reset while a write is stalled; the clear grant before it must not steer arbitration after.
    do_reset();
    mem_ack = 0; clr_valid = 1; clr_point = mkpt(3, 3);
    tick(); clr_valid = 0;
    neg(); chk("pre-rst we", mem_we, 1);
    tick(); rst = 1;
    neg(); chk("rst clr_ready", clr_ready, 0);
    tick(); rst = 0; mem_ack = 1;
    neg(); chk("post-rst we", mem_we, 0); chk("post-rst idle", idle, 1);
    tick(); clr_valid = 1; ln_valid = 1;
    neg(); chk("post-rst rr clr", clr_ready, 1); chk("post-rst rr ln", ln_ready, 0);
    tick(); clr_valid = 0; ln_valid = 0;

    // Random traffic with held requests and random backpressure.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = (i == 1500);
      if (!clr_valid || acc_clr) begin
        clr_valid = ($urandom_range(0, 3) != 0);
        clr_point = rand_pt();
        clr_color = 8'($urandom_range(0, 255));
      end
      if (!ln_valid || acc_ln) begin
        ln_valid = ($urandom_range(0, 2) != 0);
        ln_point = rand_pt();
        ln_color = 8'($urandom_range(0, 255));
      end
      mem_ack = ($urandom_range(0, 2) != 0);
    end
    tick();
    clr_valid = 0; ln_valid = 0; mem_ack = 1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
